display_scan_mux: RTL and testbench

Time-multiplexed 7-segment display driver for the clock's digit path: takes a packed vector of BCD digits from the time register, scans them one digit slot at a time, and drives one shared segment bus plus one-hot digit enables. Generalises the fixed six-digit combinational segment select into a parametrised, self-timed scanner. Adds:

- programmable slot period
- anti-ghosting blank interval
- frame-coherent input snapshot
- leading-zero suppression
- per-digit blinking
- common-anode/common-cathode polarity

Sits between the time register / set-mode logic and the display pins.

---
 rtl/display_pkg.sv | 35 +++
 rtl/bcd_to_7seg.sv | 25 ++
 rtl/display_scan_mux.sv | 144 ++++++++++++++
 tb/tb_display_scan_mux.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// ============================================================================
// display_pkg
// Shared 7-segment constants and the BCD glyph table for the display path.
// Revision: 1.0
// ============================================================================
`default_nettype none

package display_pkg;

    localparam logic [6:0] c_SEG_OFF     = 7'h00;
    localparam logic [6:0] c_SEG_OFF_CA  = 7'h7F;
    localparam logic [3:0] c_BCD_INVALID = 4'hA;

    // Segment order {g,f,e,d,c,b,a}, active-high
    function automatic logic [6:0] seg_glyph(input logic [3:0] bcd);
        logic [6:0] glyph;
        case (bcd)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = c_SEG_OFF;
        endcase
        return glyph;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_to_7seg.sv
// ============================================================================
// bcd_to_7seg
// Combinational BCD to 7-segment decoder; dark when disabled or code invalid.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_to_7seg
    import display_pkg::*;
(
    input  logic       en,
    input  logic [3:0] bcd,
    output logic [6:0] led_out
);

    always_comb begin
        led_out = c_SEG_OFF;
        if (en && (bcd < c_BCD_INVALID)) begin
            led_out = seg_glyph(bcd);
        end
    end

endmodule

`default_nettype wire

// File: rtl/display_scan_mux.sv
// ============================================================================
// display_scan_mux
// Self-timed multiplexed 7-segment scanner with blanking, frame snapshot,
// leading-zero suppression, blinking and selectable pin polarity.
// Revision: 1.0
// ============================================================================
`default_nettype none

module display_scan_mux
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 8,
    parameter bit COMMON_ANODE = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   lz_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    blink_phase,
    output logic [6:0]              led_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_start
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] c_LAST_CNT = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] c_BLANK    = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] c_LAST_IDX = IW'(NUM_DIGITS - 1);

    localparam logic [6:0]            c_LED_INACTIVE = COMMON_ANODE ? c_SEG_OFF_CA : c_SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] c_SEL_INACTIVE = {NUM_DIGITS{COMMON_ANODE}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_SHOW  = 2'd2;

    logic [1:0]            r_state;
    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [DW-1:0]         r_snap_digits;
    logic [NUM_DIGITS-1:0] r_snap_lz;
    logic [NUM_DIGITS-1:0] r_snap_blink;

    logic [1:0]            w_state_nxt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [IW-1:0]         w_idx_nxt;
    logic                  w_frame_nxt;
    logic [DW-1:0]         w_snap_digits_nxt;
    logic [NUM_DIGITS-1:0] w_snap_lz_nxt;
    logic [NUM_DIGITS-1:0] w_snap_blink_nxt;

    logic [NUM_DIGITS-1:0] w_lz_dark;
    logic [3:0]            w_digit;
    logic                  w_dec_en;
    logic [6:0]            w_seg;
    logic [NUM_DIGITS-1:0] w_sel_nxt;

    // Outputs are registered from next-state values so they match state on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_snap_digits <= '0;
            r_snap_lz     <= '0;
            r_snap_blink  <= '0;
            led_out       <= c_LED_INACTIVE;
            digit_sel     <= c_SEL_INACTIVE;
            frame_start   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            r_snap_digits <= w_snap_digits_nxt;
            r_snap_lz     <= w_snap_lz_nxt;
            r_snap_blink  <= w_snap_blink_nxt;
            led_out       <= w_seg ^ {7{COMMON_ANODE}};
            digit_sel     <= w_sel_nxt ^ {NUM_DIGITS{COMMON_ANODE}};
            frame_start   <= w_frame_nxt;
        end
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_frame_nxt = 1'b0;
        if (en) begin
            if (r_state == S_IDLE) begin
                w_frame_nxt = 1'b1;
            end else if (r_cnt == c_LAST_CNT) begin
                w_idx_nxt   = (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
                w_frame_nxt = (r_idx == c_LAST_IDX);
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
                w_idx_nxt = r_idx;
            end
            w_state_nxt = (w_cnt_nxt < c_BLANK) ? S_BLANK : S_SHOW;
        end
        w_snap_digits_nxt = w_frame_nxt ? digits_in  : r_snap_digits;
        w_snap_lz_nxt     = w_frame_nxt ? lz_mask    : r_snap_lz;
        w_snap_blink_nxt  = w_frame_nxt ? blink_mask : r_snap_blink;
    end

    // A masked digit is suppressed while it and every masked digit above it are zero
    always_comb begin : b_lz
        logic run_zero;
        run_zero  = 1'b1;
        w_lz_dark = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (w_snap_lz_nxt[i]) begin
                run_zero = run_zero & (w_snap_digits_nxt[4*i +: 4] == 4'h0);
            end
            w_lz_dark[i] = (i != 0) && w_snap_lz_nxt[i] && run_zero;
        end
    end

    always_comb begin
        w_digit   = w_snap_digits_nxt[{w_idx_nxt, 2'b00} +: 4];
        w_dec_en  = (w_state_nxt == S_SHOW)
                    && !(w_snap_blink_nxt[w_idx_nxt] && blink_phase)
                    && !w_lz_dark[w_idx_nxt];
        w_sel_nxt = '0;
        if (w_state_nxt == S_SHOW) begin
            w_sel_nxt[w_idx_nxt] = 1'b1;
        end
    end

    bcd_to_7seg u_dec (
        .en      (w_dec_en),
        .bcd     (w_digit),
        .led_out (w_seg)
    );

endmodule

`default_nettype wire

// File: tb/tb_display_scan_mux.sv
// ============================================================================
// tb_display_scan_mux
// Bench for display_scan_mux with common-cathode and common-anode instances.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_display_scan_mux;

    localparam int N = 6;
    localparam int P = 8;
    localparam int B = 2;
    localparam int F = N * P;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [23:0] digits_in;
    logic [5:0]  lz_mask;
    logic [5:0]  blink_mask;
    logic        blink_phase;
    logic [6:0]  led_out, led_out_ca;
    logic [5:0]  digit_sel, digit_sel_ca;
    logic        frame_start, frame_start_ca;

    always #5 clk = ~clk;

    display_scan_mux #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B), .COMMON_ANODE(1'b0)) dut (
        .clk(clk), .reset(reset), .en(en), .digits_in(digits_in), .lz_mask(lz_mask),
        .blink_mask(blink_mask), .blink_phase(blink_phase), .led_out(led_out),
        .digit_sel(digit_sel), .frame_start(frame_start)
    );

    display_scan_mux #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B), .COMMON_ANODE(1'b1)) dut_ca (
        .clk(clk), .reset(reset), .en(en), .digits_in(digits_in), .lz_mask(lz_mask),
        .blink_mask(blink_mask), .blink_phase(blink_phase), .led_out(led_out_ca),
        .digit_sel(digit_sel_ca), .frame_start(frame_start_ca)
    );

    // Reference model: run time since (re)start, frame snapshot, and display rules
    bit          m_run;
    int          m_t;
    logic [23:0] m_snap;
    logic [5:0]  m_lz, m_bl;
    logic [6:0]  e_led;
    logic [5:0]  e_sel;
    logic        e_fs;
    int          n_vec = 0;
    int          n_err = 0;
    bit          done  = 1'b0;

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic bit lz_dark(input int s);
        if (s == 0 || !m_lz[s]) return 1'b0;
        for (int j = s; j < N; j++) begin
            if (m_lz[j] && m_snap[4*j +: 4] != 4'h0) return 1'b0;
        end
        return 1'b1;
    endfunction

    initial begin
        int slot;
        forever begin
            @(posedge clk);
            if (reset || !en) begin
                m_run = 1'b0;
                m_t   = 0;
            end else if (!m_run) begin
                m_run = 1'b1;
                m_t   = 0;
            end else begin
                m_t++;
            end
            e_fs = m_run && (m_t % F == 0);
            if (e_fs) begin
                m_snap = digits_in;
                m_lz   = lz_mask;
                m_bl   = blink_mask;
            end
            e_led = 7'h00;
            e_sel = 6'h00;
            if (m_run && (m_t % P) >= B) begin
                slot  = (m_t / P) % N;
                e_sel = 6'(1 << slot);
                if (!(m_bl[slot] && blink_phase) && !lz_dark(slot))
                    e_led = glyph(int'(m_snap[4*slot +: 4]));
            end
            #1;
            if (!done) begin
                n_vec++;
                if (led_out !== e_led || digit_sel !== e_sel || frame_start !== e_fs ||
                    led_out_ca !== ~e_led || digit_sel_ca !== ~e_sel || frame_start_ca !== e_fs) begin
                    n_err++;
                    $display("FAIL cycle t=%0d: led/sel/fs got %h/%b/%b (ca %h/%b/%b) expected %h/%b/%b (ca %h/%b/%b)",
                             m_t, led_out, digit_sel, frame_start, led_out_ca, digit_sel_ca, frame_start_ca,
                             e_led, e_sel, e_fs, ~e_led, ~e_sel, e_fs);
                end
            end
        end
    end

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_to(input int pos);
        bit hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clk);
            if (m_run && (m_t % F) == pos) hit = 1'b1;
        end
        if (!hit) begin
            n_vec++;
            n_err++;
            $display("FAIL run_to: frame position %0d not reached within 200 cycles", pos);
        end
    endtask

    task automatic check_inactive(input string name);
        check_lit({name, "_led"},    32'(led_out),      32'h00);
        check_lit({name, "_sel"},    32'(digit_sel),    32'h00);
        check_lit({name, "_led_ca"}, 32'(led_out_ca),   32'h7F);
        check_lit({name, "_sel_ca"}, 32'(digit_sel_ca), 32'h3F);
    endtask

    initial begin
        int r;
        reset       = 1'b1;
        en          = 1'b1;
        digits_in   = 24'h123456;
        lz_mask     = 6'b0;
        blink_mask  = 6'b0;
        blink_phase = 1'b0;
        repeat (2) @(negedge clk);
        check_inactive("reset");
        check_lit("reset_fs", 32'(frame_start), 32'h0);
        reset = 1'b0;

        @(negedge clk);
        check_lit("first_fs", 32'(frame_start), 32'h1);
        check_lit("first_sel", 32'(digit_sel), 32'h00);
        repeat (2) @(negedge clk);
        check_lit("slot0_sel", 32'(digit_sel), 32'h01);
        check_lit("slot0_led", 32'(led_out), 32'h7D);
        check_lit("slot0_fs", 32'(frame_start), 32'h0);
        run_to(5*P + 2);
        check_lit("slot5_sel", 32'(digit_sel), 32'h20);
        check_lit("slot5_led", 32'(led_out), 32'h06);
        run_to(0);
        check_lit("frame2_fs", 32'(frame_start), 32'h1);

        // Leading-zero suppression
        digits_in = 24'h000407;
        lz_mask   = 6'b111100;
        run_to(0);
        run_to(2*P + 2);
        check_lit("lz_d2", 32'(led_out), 32'h66);
        run_to(3*P + 2);
        check_lit("lz_d3_led", 32'(led_out), 32'h00);
        check_lit("lz_d3_sel", 32'(digit_sel), 32'h08);
        run_to(5*P + 2);
        check_lit("lz_d5", 32'(led_out), 32'h00);
        run_to(1*P + 2);
        check_lit("lz_d1", 32'(led_out), 32'h3F);

        // Blinking
        digits_in  = 24'h123456;
        lz_mask    = 6'b0;
        blink_mask = 6'b110000;
        run_to(0);
        blink_phase = 1'b1;
        run_to(3*P + 2);
        check_lit("blink_d3", 32'(led_out), 32'h4F);
        run_to(5*P + 2);
        check_lit("blink_d5", 32'(led_out), 32'h00);
        blink_phase = 1'b0;
        run_to(4*P + 2);
        check_lit("blink_d4_lit", 32'(led_out), 32'h5B);

        // Mid-frame input change is held until the next frame
        run_to(3*P + 4);
        digits_in = 24'h987654;
        run_to(4*P + 3);
        check_lit("snap_old", 32'(led_out), 32'h5B);
        run_to(4*P + 3);
        check_lit("snap_new", 32'(led_out), 32'h7F);

        // Enable drop and restart
        run_to(2*P + 4);
        en = 1'b0;
        @(negedge clk);
        check_inactive("en_drop");
        en = 1'b1;
        @(negedge clk);
        check_lit("restart_fs", 32'(frame_start), 32'h1);
        check_lit("restart_fs_ca", 32'(frame_start_ca), 32'h1);
        check_lit("restart_sel_ca", 32'(digit_sel_ca), 32'h3F);

        // Asynchronous reset mid-slot
        run_to(1*P + 4);
        reset = 1'b1;
        #1;
        check_inactive("async_rst");
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (reset) reset = 1'b0;
            r = $urandom_range(0, 199);
            if (r < 4)       en = ~en;
            else if (r == 4) reset = 1'b1;
            if (r >= 10 && r < 30) begin
                for (int d = 0; d < N; d++)
                    digits_in[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 11));
            end
            if (r >= 30 && r < 40) lz_mask = 6'($urandom);
            if (r >= 40 && r < 48) blink_mask = 6'($urandom);
            if (r >= 48 && r < 80) blink_phase = ~blink_phase;
            if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
        end

        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
